// File: rtl/lsu_bus_ctrl.sv
// Load/store sequencer between EX and the single-port data bus (req/gnt/rvalid).
// Checks alignment, drives byte enables and replicated write data, stalls EX until the access completes.
module lsu_bus_ctrl #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_ls_valid_i,
  input  logic            ex_is_load_i,
  input  logic [XLEN-1:0] ex_ls_addr_i,
  input  logic [1:0]      ex_ls_size_i,
  input  logic            ex_ls_unsigned_i,
  input  logic [XLEN-1:0] ex_store_data_i,
  input  logic            flush_i,
  output logic            lsu_stall_o,
  output logic            lsu_done_o,
  output logic            lsu_misalign_o,
  output logic            lsu_bus_err_o,
  output logic [XLEN-1:0] lsu_load_data_o,
  output logic [1:0]      lsu_addr_2low_o,
  output logic [4:0]      lsu_l_mask_o,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  output logic [3:0]      dbus_be_o,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [XLEN-1:0] dbus_rdata_i,
  input  logic            dbus_err_i,
  output logic [1:0]      dbg_state_o
);

  // Bus handshake: the address phase completes in the cycle where dbus_req_o and
  // dbus_gnt_i are both high; until then req/we/addr/be/wdata are held stable.
  // A granted load completes its data phase in the first cycle with dbus_rvalid_i
  // high (dbus_err_i is only meaningful in that cycle). Stores have no data phase.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int            CW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_flushed;
  logic            r_misalign;
  logic            r_bus_err;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_load_data;
  logic [3:0]      r_be;
  logic            r_we;
  logic [4:0]      r_mask;
  logic [1:0]      r_addr_2low;

  logic            w_accept;
  logic            w_aligned;
  logic            w_timeout;
  logic            w_kill;
  logic [3:0]      w_be;
  logic [4:0]      w_mask;
  logic [XLEN-1:0] w_wdata;

  assign w_accept  = ex_ls_valid_i & ~flush_i;
  assign w_timeout = (r_cnt == TO_LAST);
  assign w_kill    = r_flushed | flush_i;

  always_comb begin
    w_aligned = 1'b1;
    w_be      = 4'b1111;
    w_mask    = 5'b11111;
    w_wdata   = ex_store_data_i;
    case (ex_ls_size_i)
      2'b00: begin
        w_aligned = 1'b1;
        w_be      = 4'b0001 << ex_ls_addr_i[1:0];
        w_mask    = {~ex_ls_unsigned_i, 4'b0001};
        w_wdata   = {(XLEN/8){ex_store_data_i[7:0]}};
      end
      2'b01: begin
        w_aligned = ~ex_ls_addr_i[0];
        w_be      = 4'b0011 << {ex_ls_addr_i[1], 1'b0};
        w_mask    = {~ex_ls_unsigned_i, 4'b0011};
        w_wdata   = {(XLEN/16){ex_store_data_i[15:0]}};
      end
      default: begin
        // Word accesses always sign-extend: LW has no unsigned variant on RV32.
        w_aligned = (ex_ls_addr_i[1:0] == 2'b00);
        w_be      = 4'b1111;
        w_mask    = 5'b11111;
        w_wdata   = ex_store_data_i;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_flushed   <= 1'b0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_load_data <= '0;
      r_be        <= '0;
      r_we        <= 1'b0;
      r_mask      <= '0;
      r_addr_2low <= '0;
    end else begin
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_aligned) begin
              r_addr      <= {ex_ls_addr_i[XLEN-1:2], 2'b00};
              r_wdata     <= w_wdata;
              r_be        <= w_be;
              r_we        <= ~ex_is_load_i;
              r_mask      <= w_mask;
              r_addr_2low <= ex_ls_addr_i[1:0];
              r_cnt       <= '0;
              r_flushed   <= 1'b0;
              r_state     <= S_REQ;
            end else begin
              r_misalign <= 1'b1;
            end
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (dbus_gnt_i) begin
            // A granted access is committed on the bus; a same-cycle flush only
            // suppresses its completion later.
            r_flushed <= flush_i;
            r_state   <= r_we ? S_DONE : S_WAIT;
          end else if (flush_i) begin
            r_state <= S_IDLE;
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (flush_i) begin
            r_flushed <= 1'b1;
          end
          if (dbus_rvalid_i) begin
            if (w_kill) begin
              r_state <= S_IDLE;
            end else begin
              if (dbus_err_i) begin
                r_bus_err <= 1'b1;
              end else begin
                r_load_data <= dbus_rdata_i;
              end
              r_state <= S_DONE;
            end
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_DONE: begin
          r_flushed <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stall is combinational so EX freezes in the very cycle the op is accepted.
  assign lsu_stall_o     = ((r_state == S_IDLE) & w_accept & w_aligned) |
                           (r_state == S_REQ) | (r_state == S_WAIT);
  assign lsu_done_o      = (r_state == S_DONE) & ~w_kill;
  assign lsu_misalign_o  = r_misalign;
  assign lsu_bus_err_o   = r_bus_err;
  assign lsu_load_data_o = r_load_data;
  assign lsu_addr_2low_o = r_addr_2low;
  assign lsu_l_mask_o    = r_mask;
  assign dbus_req_o      = (r_state == S_REQ);
  assign dbus_we_o       = r_we;
  assign dbus_addr_o     = r_addr;
  assign dbus_wdata_o    = r_wdata;
  assign dbus_be_o       = r_be;
  assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl: a bus slave model, a stimulus process, and a
// monitor that pops expected completions and bus grants from scoreboard queues.
module tb_lsu_bus_ctrl;

  localparam int EW = 43;
  localparam int BW = 69;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_ls_valid_i = 1'b0;
  logic        ex_is_load_i = 1'b0;
  logic [31:0] ex_ls_addr_i = '0;
  logic [1:0]  ex_ls_size_i = '0;
  logic        ex_ls_unsigned_i = 1'b0;
  logic [31:0] ex_store_data_i = '0;
  logic        flush_i = 1'b0;
  logic        lsu_stall_o, lsu_done_o, lsu_misalign_o, lsu_bus_err_o;
  logic [31:0] lsu_load_data_o;
  logic [1:0]  lsu_addr_2low_o;
  logic [4:0]  lsu_l_mask_o;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_gnt_i = 1'b0;
  logic        dbus_rvalid_i = 1'b0;
  logic [31:0] dbus_rdata_i = '0;
  logic        dbus_err_i = 1'b0;
  logic [1:0]  dbg_state_o;

  lsu_bus_ctrl #(.XLEN(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_ls_valid_i(ex_ls_valid_i), .ex_is_load_i(ex_is_load_i),
    .ex_ls_addr_i(ex_ls_addr_i), .ex_ls_size_i(ex_ls_size_i),
    .ex_ls_unsigned_i(ex_ls_unsigned_i), .ex_store_data_i(ex_store_data_i),
    .flush_i(flush_i),
    .lsu_stall_o(lsu_stall_o), .lsu_done_o(lsu_done_o),
    .lsu_misalign_o(lsu_misalign_o), .lsu_bus_err_o(lsu_bus_err_o),
    .lsu_load_data_o(lsu_load_data_o), .lsu_addr_2low_o(lsu_addr_2low_o),
    .lsu_l_mask_o(lsu_l_mask_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o),
    .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i),
    .dbus_rdata_i(dbus_rdata_i), .dbus_err_i(dbus_err_i),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [BW-1:0] bus_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int req_cyc_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] ev(input logic d, input logic m, input logic e,
                                       input logic [31:0] ld, input logic [4:0] mk,
                                       input logic [1:0] lo);
    return {d, m, e, ld, mk, lo};
  endfunction

  function automatic logic [BW-1:0] bw(input logic we, input logic [31:0] a,
                                       input logic [3:0] be, input logic [31:0] wd);
    return {we, a, be, wd};
  endfunction

  // ---------------- bus slave model ----------------
  int          gnt_delay = 0;
  int          rv_extra  = 0;
  logic [31:0] rd_word   = '0;
  logic        rd_err    = 1'b0;
  int          late_at   = -1;
  int          gnt_cnt   = 0;
  bit          rv_pend   = 1'b0;
  int          rv_cnt    = 0;

  always @(posedge clk) begin
    #1;
    dbus_gnt_i    = 1'b0;
    dbus_rvalid_i = 1'b0;
    dbus_err_i    = 1'b0;
    if (rv_pend) begin
      if (rv_cnt == 0) begin
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = rd_word;
        dbus_err_i    = rd_err;
        rv_pend       = 1'b0;
      end else begin
        rv_cnt--;
      end
    end
    if (dbus_req_o) begin
      if (gnt_delay >= 0 && gnt_cnt == gnt_delay) begin
        dbus_gnt_i = 1'b1;
        gnt_cnt    = 0;
        if (!dbus_we_o) begin
          rv_pend = 1'b1;
          rv_cnt  = rv_extra;
        end
      end else begin
        gnt_cnt++;
      end
    end else begin
      gnt_cnt = 0;
    end
    if (cyc == late_at) begin
      dbus_gnt_i    = 1'b1;
      dbus_rvalid_i = 1'b1;
      dbus_rdata_i  = 32'h9999_9999;
    end
  end

  // ---------------- monitor ----------------
  bit            prev_hold = 1'b0;
  logic [BW-1:0] prev_bus  = '0;

  always @(negedge clk) begin
    logic [EW-1:0] a_ev;
    logic [BW-1:0] a_bus;
    if (rst_n) begin
      a_ev  = ev(lsu_done_o, lsu_misalign_o, lsu_bus_err_o, lsu_load_data_o,
                 lsu_l_mask_o, lsu_addr_2low_o);
      a_bus = bw(dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o);
      if (lsu_done_o || lsu_misalign_o || lsu_bus_err_o) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got %0h expected none", a_ev);
        end else begin
          check("event", a_ev, exp_q.pop_front());
        end
      end
      if (dbus_req_o && dbus_gnt_i) begin
        if (bus_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_grant: got %0h expected none", a_bus);
        end else begin
          check("bus_txn", a_bus, bus_q.pop_front());
        end
      end
      if (dbus_req_o) req_cyc_total++;
      if (dbus_req_o && prev_hold) check("req_stable", a_bus, prev_bus);
      prev_hold = dbus_req_o && !dbus_gnt_i;
      prev_bus  = a_bus;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic ld, input logic [31:0] a, input logic [1:0] sz,
                          input logic uns, input logic [31:0] sd);
    ex_ls_valid_i    = 1'b1;
    ex_is_load_i     = ld;
    ex_ls_addr_i     = a;
    ex_ls_size_i     = sz;
    ex_ls_unsigned_i = uns;
    ex_store_data_i  = sd;
  endtask

  task automatic count_stall(output int n);
    bit s;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s = lsu_stall_o;
      step();
      ex_ls_valid_i = 1'b0;
      if (!s) break;
      n++;
    end
  endtask

  task automatic run_op(input logic ld, input logic [31:0] a, input logic [1:0] sz,
                        input logic uns, input logic [31:0] sd, output int stall_n);
    step();
    drive_op(ld, a, sz, uns, sd);
    count_stall(stall_n);
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check({tag, "_stall"},  lsu_stall_o, 1'b0);
    check({tag, "_done"},   lsu_done_o, 1'b0);
    check({tag, "_mis"},    lsu_misalign_o, 1'b0);
    check({tag, "_berr"},   lsu_bus_err_o, 1'b0);
    check({tag, "_ldata"},  lsu_load_data_o, 32'h0);
    check({tag, "_2low"},   lsu_addr_2low_o, 2'b00);
    check({tag, "_mask"},   lsu_l_mask_o, 5'b00000);
    check({tag, "_req"},    dbus_req_o, 1'b0);
    check({tag, "_we"},     dbus_we_o, 1'b0);
    check({tag, "_addr"},   dbus_addr_o, 32'h0);
    check({tag, "_wdata"},  dbus_wdata_o, 32'h0);
    check({tag, "_be"},     dbus_be_o, 4'h0);
    check({tag, "_state"},  dbg_state_o, 2'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int st;
    int r0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_vals("rst");

    // LW 0x1000, ideal bus
    gnt_delay = 0; rv_extra = 0; rd_word = 32'hDEAD_BEEF; rd_err = 1'b0;
    bus_q.push_back(bw(1'b0, 32'h1000, 4'hF, 32'h0));
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 5'b11111, 2'b00));
    run_op(1'b1, 32'h1000, 2'b10, 1'b0, 32'h0, st);
    check("lw_stall_cycles", st, 3);

    // SB 0x1003, grant after 4 waiting cycles
    gnt_delay = 4; r0 = req_cyc_total;
    bus_q.push_back(bw(1'b1, 32'h1000, 4'b1000, 32'h7878_7878));
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 5'b10001, 2'b11));
    run_op(1'b0, 32'h1003, 2'b00, 1'b0, 32'h1234_5678, st);
    check("sb_stall_cycles", st, 6);
    check("sb_req_cycles", req_cyc_total - r0, 5);

    // LH 0x1001 misaligned
    gnt_delay = 0; r0 = req_cyc_total;
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 5'b10001, 2'b11));
    run_op(1'b1, 32'h1001, 2'b01, 1'b0, 32'h0, st);
    check("lh_mis_stall", st, 0);
    check("lh_mis_no_req", req_cyc_total - r0, 0);

    // LHU 0x1002
    rd_word = 32'hCAFE_F00D;
    bus_q.push_back(bw(1'b0, 32'h1000, 4'b1100, 32'h0));
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 5'b00011, 2'b10));
    run_op(1'b1, 32'h1002, 2'b01, 1'b1, 32'h0, st);
    check("lhu_stall_cycles", st, 3);

    // LW 0x1006 misaligned word
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 5'b00011, 2'b10));
    run_op(1'b1, 32'h1006, 2'b10, 1'b0, 32'h0, st);
    check("lw_mis_stall", st, 0);

    // misaligned op presented under flush is not accepted at all
    flush_i = 1'b1;
    run_op(1'b1, 32'h1002, 2'b10, 1'b0, 32'h0, st);
    flush_i = 1'b0;
    check("flushed_accept_stall", st, 0);

    // LW 0x2004, flush in REQ without grant
    gnt_delay = -1; r0 = req_cyc_total;
    step(); drive_op(1'b1, 32'h2004, 2'b10, 1'b0, 32'h0);
    step(); ex_ls_valid_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    check("flush_req_before", dbus_req_o, 1'b1);
    step(); flush_i = 1'b0;
    @(negedge clk);
    check("flush_req_dropped", dbus_req_o, 1'b0);
    check("flush_req_stall", lsu_stall_o, 1'b0);
    check("flush_req_state", dbg_state_o, 2'd0);
    check("flush_req_cycles", req_cyc_total - r0, 1);
    repeat (3) step();

    // LW 0x2008, flush in WAIT: data discarded, no done
    gnt_delay = 0; rv_extra = 3; rd_word = 32'h1111_1111;
    bus_q.push_back(bw(1'b0, 32'h2008, 4'hF, 32'h0));
    step(); drive_op(1'b1, 32'h2008, 2'b10, 1'b0, 32'h0);
    step(); ex_ls_valid_i = 1'b0;
    step(); flush_i = 1'b1;
    @(negedge clk);
    check("flush_wait_state", dbg_state_o, 2'd2);
    step(); flush_i = 1'b0;
    count_stall(st);
    check("flush_wait_stall", st, 3);
    check("flush_wait_ldata", lsu_load_data_o, 32'hCAFE_F00D);
    rv_extra = 0;

    // LB 0x3002, read error
    rd_word = 32'h5555_5555; rd_err = 1'b1;
    bus_q.push_back(bw(1'b0, 32'h3000, 4'b0100, 32'h0));
    exp_q.push_back(ev(1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 5'b10001, 2'b10));
    run_op(1'b1, 32'h3002, 2'b00, 1'b0, 32'h0, st);
    check("lb_err_stall", st, 3);
    rd_err = 1'b0;

    // SW 0x4000
    bus_q.push_back(bw(1'b1, 32'h4000, 4'hF, 32'hA5A5_0F0F));
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 5'b11111, 2'b00));
    run_op(1'b0, 32'h4000, 2'b11, 1'b0, 32'hA5A5_0F0F, st);
    check("sw_stall_cycles", st, 2);

    // SH 0x4006, one wait cycle
    gnt_delay = 1;
    bus_q.push_back(bw(1'b1, 32'h4004, 4'b1100, 32'hBEEF_BEEF));
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 5'b10011, 2'b10));
    run_op(1'b0, 32'h4006, 2'b01, 1'b0, 32'h0000_BEEF, st);
    check("sh_stall_cycles", st, 3);

    // SW 0x6000, flush arrives in DONE: done suppressed
    gnt_delay = 0;
    bus_q.push_back(bw(1'b1, 32'h6000, 4'hF, 32'h0000_0001));
    step(); drive_op(1'b0, 32'h6000, 2'b10, 1'b0, 32'h1);
    step(); ex_ls_valid_i = 1'b0;
    step(); flush_i = 1'b1;
    @(negedge clk);
    check("flush_done_state", dbg_state_o, 2'd3);
    check("flush_done_pulse", lsu_done_o, 1'b0);
    step(); flush_i = 1'b0;
    repeat (2) step();

    // LW 0x5000, grant never: timeout after 8 REQ cycles
    gnt_delay = -1; r0 = req_cyc_total;
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 5'b11111, 2'b00));
    run_op(1'b1, 32'h5000, 2'b10, 1'b0, 32'h0, st);
    check("timeout_stall", st, 9);
    check("timeout_req_cycles", req_cyc_total - r0, 8);
    late_at = cyc + 1;
    repeat (3) step();
    @(negedge clk);
    check("late_rsp_state", dbg_state_o, 2'd0);
    check("late_rsp_req", dbus_req_o, 1'b0);
    check("late_rsp_ldata", lsu_load_data_o, 32'hCAFE_F00D);

    // reset in the middle of a transaction
    step(); drive_op(1'b1, 32'h7000, 2'b10, 1'b0, 32'h0);
    step(); ex_ls_valid_i = 1'b0;
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    check_reset_vals("midrst");
    gnt_delay = 0;
    repeat (2) step();

    check("exp_q_drained", exp_q.size(), 0);
    check("bus_q_drained", bus_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
